mem_dumper: RTL and testbench

MEM_DUMPER -- requirements
Module: mem_dumper

---
 rtl/mem_dumper.sv | 170 +++++++++++++++++
 tb/tb_mem_dumper.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dumper.sv
// mem_dumper: reads DUMP_SIZE bytes of word-organised memory and streams them
// out of an 8N1 UART, one 32-bit word at a time, least significant byte first.
module mem_dumper #(
   parameter int SERIAL_WCNT = 50,
   parameter int DUMP_SIZE   = 512*1024
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   output logic [31:0] ADDR,
   output logic        RE,
   input  logic [31:0] RDATA,
   output logic        TXD,
   output logic        BUSY,
   output logic        DONE
);

   localparam int            CW       = (SERIAL_WCNT > 1) ? $clog2(SERIAL_WCNT) : 1;
   localparam logic [CW-1:0] BIT_LAST = CW'(SERIAL_WCNT - 1);
   localparam logic [31:0]   DUMP_END = 32'(DUMP_SIZE);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_LATCH = 3'd2,
      S_SEND  = 3'd3,
      S_NEXT  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   shift_q, shift_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [3:0]    bit_idx_q, bit_idx_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic          re_q, re_d;
   logic          txd_q, txd_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [31:0]   addr_inc_s;

   // Line level of 8N1 frame position idx: 0 = start, 1..8 = data LSB first, 9 = stop.
   function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] data);
      logic b;
      case (idx)
         4'd0:    b = 1'b0;
         4'd1:    b = data[0];
         4'd2:    b = data[1];
         4'd3:    b = data[2];
         4'd4:    b = data[3];
         4'd5:    b = data[4];
         4'd6:    b = data[5];
         4'd7:    b = data[6];
         4'd8:    b = data[7];
         default: b = 1'b1;
      endcase
      return b;
   endfunction

   assign addr_inc_s = addr_q + 32'd4;

   // Next-state logic; TXD is computed from the next state so it lines up with SEND exactly.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      re_d       = 1'b0;
      txd_d      = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               addr_d  = 32'd0;
               busy_d  = 1'b1;
               re_d    = 1'b1;
               state_d = S_READ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            shift_d    = RDATA;
            byte_idx_d = 2'd0;
            bit_idx_d  = 4'd0;
            bit_cnt_d  = '0;
            state_d    = S_SEND;
         end
         S_SEND: begin
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = '0;
               if (bit_idx_q == 4'd9) begin
                  bit_idx_d = 4'd0;
                  if (byte_idx_q == 2'd3) begin
                     state_d = S_NEXT;
                  end else begin
                     // next byte's start bit follows the stop bit with no gap
                     byte_idx_d = byte_idx_q + 2'd1;
                     shift_d    = {8'h00, shift_q[31:8]};
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         S_NEXT: begin
            addr_d = addr_inc_s;
            if (addr_inc_s >= DUMP_END) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               re_d    = 1'b1;
               state_d = S_READ;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
      if (state_d == S_SEND) begin
         txd_d = frame_bit(bit_idx_d, shift_d[7:0]);
      end else begin
         txd_d = 1'b1;
      end
   end

   // State, counters and registered outputs; reset forces the line idle-high at once.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= S_IDLE;
         addr_q     <= 32'd0;
         shift_q    <= 32'd0;
         bit_cnt_q  <= '0;
         bit_idx_q  <= 4'd0;
         byte_idx_q <= 2'd0;
         re_q       <= 1'b0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         re_q       <= re_d;
         txd_q      <= txd_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign ADDR = addr_q;
   assign RE   = re_q;
   assign TXD  = txd_q;
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_mem_dumper.sv
// tb_mem_dumper: scoreboard bench. Stimulus pushes the expected UART bytes and
// read addresses; independent monitors decode TXD/RE/DONE and compare.
module tb_mem_dumper;

   localparam int W = 4;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   logic        start8, re8, txd8, busy8, done8;
   logic [31:0] addr8, rdata8;
   logic        start16, re16, txd16, busy16, done16;
   logic [31:0] addr16, rdata16;
   logic [31:0] mem8  [0:1];
   logic [31:0] mem16 [0:3];

   mem_dumper #(.SERIAL_WCNT(W), .DUMP_SIZE(8)) u_dut8 (
      .CLK(CLK), .RST(RST), .START(start8), .ADDR(addr8), .RE(re8),
      .RDATA(rdata8), .TXD(txd8), .BUSY(busy8), .DONE(done8));

   mem_dumper #(.SERIAL_WCNT(W), .DUMP_SIZE(16)) u_dut16 (
      .CLK(CLK), .RST(RST), .START(start16), .ADDR(addr16), .RE(re16),
      .RDATA(rdata16), .TXD(txd16), .BUSY(busy16), .DONE(done16));

   // memories answer one cycle after the read strobe
   always @(posedge CLK) if (re8)  rdata8  <= mem8[addr8[2]];
   always @(posedge CLK) if (re16) rdata16 <= mem16[addr16[3:2]];

   // observe whichever instance is under test
   logic sel16;
   logic obs_txd, obs_re, obs_busy, obs_done;
   logic [31:0] obs_addr;
   assign obs_txd  = sel16 ? txd16  : txd8;
   assign obs_re   = sel16 ? re16   : re8;
   assign obs_busy = sel16 ? busy16 : busy8;
   assign obs_done = sel16 ? done16 : done8;
   assign obs_addr = sel16 ? addr16 : addr8;

   typedef struct { logic [7:0] b; int gap; } exp_byte_t;
   exp_byte_t   exp_q[$];
   logic [31:0] exp_addr_q[$];
   logic [7:0]  rx_bytes[$];
   int unsigned cyc = 0;
   int unsigned last_stop_cyc = 0;
   int unsigned last_done_cyc = 0;
   int unsigned re0_cyc = 0;
   int          done_seen = 0;
   int          nchk = 0;
   int          npass = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // reference: a dump sends every word LSB first; 3 idle cycles between words
   task automatic expect_dump(input bit use16);
      exp_byte_t   e;
      logic [31:0] word;
      int          nw;
      nw = use16 ? 4 : 2;
      for (int w = 0; w < nw; w++) begin
         word = use16 ? mem16[w] : mem8[w];
         exp_addr_q.push_back(32'(w * 4));
         for (int k = 0; k < 4; k++) begin
            e.b   = word[8*k +: 8];
            e.gap = (k != 0) ? 0 : ((w == 0) ? -1 : 3);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic pulse_start(input bit use16);
      if (use16) start16 = 1'b1;
      else       start8  = 1'b1;
      tick(1);
      start8  = 1'b0;
      start16 = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      int d0;
      n  = 0;
      d0 = done_seen;
      while (done_seen == d0 && n < budget) begin
         tick(1);
         n++;
      end
      check("done_timeout", 32'(done_seen != d0), 32'd1);
   endtask

   // UART monitor: decode frames, check bit timing, byte value and idle gap
   initial begin : uart_mon
      exp_byte_t  e;
      logic [9:0] fr;
      logic [7:0] got;
      int         gap, gap_before, bad_idx;
      bit         aborted;
      gap = 0;
      forever begin
         @(negedge CLK);
         if (RST === 1'b1) begin
            gap = 0;
         end else if (obs_txd !== 1'b0) begin
            gap++;
         end else begin
            gap_before = gap;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
            end else begin
               check("frame_unexpected", 32'd1, 32'd0);
               e.b   = 8'h00;
               e.gap = -1;
            end
            fr      = {1'b1, e.b, 1'b0};
            got     = 8'h00;
            bad_idx = -1;
            aborted = 1'b0;
            for (int s = 0; s < 10*W; s++) begin
               if (s > 0) begin
                  @(negedge CLK);
                  if ((s % W) == 0) fr = fr >> 1;
               end
               if (RST === 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               if (obs_txd !== fr[0] && bad_idx < 0) bad_idx = s;
               if ((s % W) == (W/2) && s >= W && s < 9*W) got = {obs_txd, got[7:1]};
            end
            if (!aborted) begin
               check("frame_byte", {24'h0, got}, {24'h0, e.b});
               check("frame_bit_timing", bad_idx, -1);
               if (e.gap >= 0) check("frame_gap", gap_before, e.gap);
               rx_bytes.push_back(got);
               last_stop_cyc = cyc;
            end
            gap = 0;
         end
      end
   end

   // control monitor: read strobes and completion pulse
   initial begin : ctl_mon
      forever begin
         @(negedge CLK);
         if (RST !== 1'b1 && obs_re === 1'b1) begin
            if (obs_addr == 32'd0) re0_cyc = cyc;
            if (exp_addr_q.size() == 0) check("re_unexpected", 32'd1, 32'd0);
            else check("re_addr", obs_addr, exp_addr_q.pop_front());
         end
         if (RST !== 1'b1 && obs_done === 1'b1) begin
            done_seen++;
            last_done_cyc = cyc;
            check("done_delay", cyc - last_stop_cyc, 32'd2);
            check("busy_at_done", {31'd0, obs_busy}, 32'd0);
         end
      end
   end

   initial begin : stim
      int unsigned d1;
      logic [31:0] loader_mem [0:3];
      RST     = 1'b1;
      start8  = 1'b0;
      start16 = 1'b0;
      sel16   = 1'b0;
      for (int i = 0; i < 4; i++) mem16[i] = 32'd0;
      mem8[0] = 32'h44332211;
      mem8[1] = 32'hDDCCBBAA;
      tick(3);
      check("rst_txd",  {31'd0, obs_txd},  32'd1);
      check("rst_busy", {31'd0, obs_busy}, 32'd0);
      check("rst_re",   {31'd0, obs_re},   32'd0);
      check("rst_done", {31'd0, obs_done}, 32'd0);
      check("rst_addr", obs_addr, 32'd0);
      check("rst_txd16", {31'd0, txd16}, 32'd1);
      RST = 1'b0;
      tick(5);
      check("idle_busy", {31'd0, obs_busy}, 32'd0);

      // basic two-word dump
      expect_dump(1'b0);
      pulse_start(1'b0);
      wait_done(2000);
      tick(5);
      check("done_count_basic", done_seen, 32'd1);

      // START re-asserted during byte 2 of word 0 is ignored
      expect_dump(1'b0);
      pulse_start(1'b0);
      tick(85);
      start8 = 1'b1;
      tick(3);
      start8 = 1'b0;
      wait_done(2000);
      tick(20);
      check("done_count_ignore", done_seen, 32'd2);

      // reset in data bit 0 (a zero) of byte 1
      expect_dump(1'b0);
      pulse_start(1'b0);
      tick(47);
      check("pre_rst_txd_low", {31'd0, obs_txd}, 32'd0);
      RST = 1'b1;
      #1;
      check("rst_mid_txd",  {31'd0, obs_txd},  32'd1);
      check("rst_mid_busy", {31'd0, obs_busy}, 32'd0);
      exp_q.delete();
      exp_addr_q.delete();
      tick(2);
      RST = 1'b0;
      tick(30);
      check("post_rst_idle_busy", {31'd0, obs_busy}, 32'd0);
      check("post_rst_done_count", done_seen, 32'd2);
      expect_dump(1'b0);
      pulse_start(1'b0);
      wait_done(2000);
      tick(5);
      check("done_count_restart", done_seen, 32'd3);

      // START held through DONE starts the next dump right away
      expect_dump(1'b0);
      expect_dump(1'b0);
      start8 = 1'b1;
      wait_done(2000);
      start8 = 1'b0;
      d1 = last_done_cyc;
      wait_done(2000);
      check("held_start_re_delay", re0_cyc - d1, 32'd1);
      tick(20);
      check("done_count_held", done_seen, 32'd5);

      // loopback into a byte-stream loader model (16-byte image), random data
      sel16 = 1'b1;
      tick(2);
      for (int it = 0; it < 2; it++) begin
         for (int i = 0; i < 4; i++) mem16[i] = $urandom;
         rx_bytes.delete();
         tick($urandom_range(1, 6));
         expect_dump(1'b1);
         pulse_start(1'b1);
         wait_done(4000);
         tick(5);
         check("loader_byte_count", rx_bytes.size(), 32'd16);
         for (int i = 0; i < 4; i++) begin
            loader_mem[i] = {rx_bytes[4*i+3], rx_bytes[4*i+2], rx_bytes[4*i+1], rx_bytes[4*i]};
         end
         for (int i = 0; i < 4; i++) check("loader_word", loader_mem[i], mem16[i]);
      end
      check("done_count_final", done_seen, 32'd7);
      check("exp_bytes_left", exp_q.size(), 32'd0);
      check("exp_reads_left", exp_addr_q.size(), 32'd0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
